demux_route_sched: RTL and testbench
====================================

Name: demux_route_sched

Overview:
- Controller that owns the select line of the 1-input/2-output demux on the FPGA datapath.
- Arbitrates between two requesters, each wanting the shared signal steered to its path: path 0 → x0, path 1 → x1.
- Enforces break-before-make. During a guard interval both destinations are starved (route_en=0) while sel settles.
- Also enforces a minimum hold time and an optional maximum hold time for fairness.

Parameters:
- GUARD_CYCLES, 4: dead cycles inserted on every sel change; 0 is legal (no dead time).
- MIN_HOLD, 16: cycles an owner keeps the path before it can be preempted.
- MAX_HOLD, 256: cycles after which a pending other requester preempts the owner; 0 = never preempt.
- CNT_W, 9: width of the internal hold/guard counters; must hold max(GUARD_CYCLES, MAX_HOLD).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  2  req[i]=1: requester i wants path i; level-held while needed; dropping it releases the path
- gnt  out  2  one-hot or zero; gnt[i]=1: requester i owns the demux and its data is routed
- sel  out  1  demux select; 0 = path 0 (x0), 1 = path 1 (x1)
- route_en  out  1  1 = datapath input gated through to the selected output; 0 = forced low
- busy  out  1  1 in any state other than IDLE
- switch_cnt  out  16  only with the optional feature; otherwise absent

Behaviour:
- Reset (async, any state):
  - state=IDLE; sel=0; gnt=00; route_en=0; busy=0.
  - last_owner=1, so requester 0 wins the first tie.
  - Counters=0.
- All outputs are registered. Every decision uses req sampled at the clk edge.
- States: IDLE, GUARD, OWN.
- IDLE:
  - No req: remain. sel holds its last value.
  - Winner selection: a single req wins; if both are set, the winner is !last_owner (round-robin).
  - Winner path == sel: go to OWN. gnt and route_en assert on the edge after req is first sampled (1-cycle latency).
  - Winner path != sel:
    - GUARD_CYCLES>0: sel toggles on that edge, enter GUARD.
    - GUARD_CYCLES==0: go to OWN with the new sel on the same edge.
- GUARD:
  - gnt=00, route_en=0, guard counter counts up.
  - After exactly GUARD_CYCLES cycles in GUARD, enter OWN for the pending winner.
  - Winner's req drops during GUARD:
    - other req set: that requester becomes the winner; sel re-toggles and the guard restarts.
    - otherwise: go to IDLE, keeping the new sel.
  - Sequence: sel changes on the edge entering GUARD; route_en rises no earlier than GUARD_CYCLES cycles later.
- OWN:
  - gnt[owner]=1, route_en=1, last_owner=owner; hold counter increments and saturates at 2^CNT_W-1.
  - Release: req[owner]=0 → gnt and route_en drop on the next edge. This applies even before MIN_HOLD.
    - other req set: switch via GUARD.
    - otherwise: IDLE.
  - Preemption: MAX_HOLD!=0, the other req is set, and hold counter ≥ max(MIN_HOLD, MAX_HOLD) → gnt and route_en drop next edge, switch via GUARD.
  - While hold < MIN_HOLD, no preemption occurs regardless of the other req.
- Simultaneous events:
  - Release and preemption on the same cycle: treated as release (same resulting transition).
  - Both reqs rising together in IDLE: round-robin as above.
- Invariants:
  - gnt never 11.
  - gnt[i]=1 implies sel==i and route_en=1.
  - route_en=0 on any cycle where sel changed during the previous GUARD_CYCLES cycles.
- Reset mid-OWN or mid-GUARD: outputs drop immediately (asynchronously) to reset values; sel returns to 0.

Optional Feature:
- Macro: DEMUX_ROUTE_SCHED_STATS_EN.
- Defined: adds output switch_cnt[15:0].
  - Increments by 1 on every sel toggle, including guard restarts.
  - Saturates at 0xFFFF; cleared by rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req=01 held → gnt=01 one cycle later, sel=0, route_en=1, no guard; busy=1 from the same edge.
- Path 0 owned, req=10 with req[0] dropped (GUARD_CYCLES=4) → gnt=00 next edge, sel=1 on that edge, route_en=0 for 4 cycles, then gnt=10, route_en=1.
- Both req from reset → gnt=01 first. req[0] held with MAX_HOLD=256 → after 256 OWN cycles gnt=00, 4 guard cycles, then gnt=10.
- MIN_HOLD=16, MAX_HOLD=8, both req held → owner keeps gnt for exactly 16 cycles before revocation.
- In GUARD toward path 1, req[1] drops while req[0] stays → sel back to 0, guard restarts (4 cycles), then gnt=01. With the stats macro, switch_cnt increments by 2.
- rst pulsed mid-OWN on path 1 → gnt=00, sel=0, route_en=0 immediately; after release, req=10 → full 4-cycle guard before gnt=10.

Source files
------------

// File: rtl/demux_route_sched_if.sv
// demux_route_sched_if: requester/controller bundle for the demux route scheduler.
// master = requester side (drives req), slave = controller side (drives the rest).
interface demux_route_sched_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       route_en;
    logic       busy;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  route_en,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output route_en,
        output busy
    );
endinterface

// File: rtl/demux_route_sched.sv
// demux_route_sched: owns the select line of a 1-in/2-out demux.
// Two requesters compete for their own output path. A change of sel is
// bracketed by a guard interval with route_en low (break-before-make).
// An owner keeps the path for at least MIN_HOLD cycles and, when MAX_HOLD
// is non-zero, is preempted by a waiting requester after
// max(MIN_HOLD, MAX_HOLD) cycles. All outputs are registered.
// Optional feature: define DEMUX_ROUTE_SCHED_STATS_EN to add switch_cnt,
// a saturating count of sel toggles.
module demux_route_sched #(
    parameter int GUARD_CYCLES = 4,
    parameter int MIN_HOLD     = 16,
    parameter int MAX_HOLD     = 256,
    parameter int CNT_W        = 9
) (
    input  logic               clk,
    input  logic               rst,
    demux_route_sched_if.slave bus
`ifdef DEMUX_ROUTE_SCHED_STATS_EN
    ,
    output logic [15:0]        switch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        OWN   = 2'd2
    } state_t;

    // Preemption threshold: a waiting requester can never cut in before MIN_HOLD.
    localparam int               HOLD_LIM   = (MIN_HOLD > MAX_HOLD) ? MIN_HOLD : MAX_HOLD;
    localparam logic [CNT_W-1:0] HOLD_LIM_C = CNT_W'(HOLD_LIM);
    localparam logic [CNT_W-1:0] GUARD_C    = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // Registered state. In GUARD and OWN, sel doubles as the pending/owning
    // path, so no separate owner register is needed.
    state_t           state;
    logic             sel_q;
    logic             last_owner;
    logic [CNT_W-1:0] guard_cnt;
    logic [CNT_W-1:0] hold_cnt;

    // Next-state values.
    state_t           state_nxt;
    logic             sel_nxt;
    logic             last_owner_nxt;
    logic [CNT_W-1:0] guard_cnt_nxt;
    logic [CNT_W-1:0] hold_cnt_nxt;

    // Next output values, registered alongside the state.
    logic [1:0]       gnt_nxt;
    logic             route_en_nxt;
    logic             busy_nxt;

    // Decision helpers.
    logic             win;      // IDLE arbitration winner
    logic             start;    // begin routing toward tgt this edge
    logic             tgt;      // path being switched/routed to
    logic             leave;    // owner gives up the path (release or preemption)
    logic             preempt;

    // State register: FSM state, counters and all registered outputs.
    // NOTE: reset is asynchronous and every sequential assignment is non-blocking,
    // so all flops update together from values computed in the combinational blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sel_q        <= 1'b0;
            last_owner   <= 1'b1;
            guard_cnt    <= '0;
            hold_cnt     <= '0;
            bus.gnt      <= 2'b00;
            bus.route_en <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_nxt;
            sel_q        <= sel_nxt;
            last_owner   <= last_owner_nxt;
            guard_cnt    <= guard_cnt_nxt;
            hold_cnt     <= hold_cnt_nxt;
            bus.gnt      <= gnt_nxt;
            bus.route_en <= route_en_nxt;
            bus.busy     <= busy_nxt;
        end
    end

    assign bus.sel = sel_q;

    // Next-state logic: arbitration, guard sequencing, hold/preemption.
    // NOTE: every variable gets a default first so no path leaves one unassigned
    // (which would otherwise infer a latch).
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel_q;
        last_owner_nxt = last_owner;
        guard_cnt_nxt  = guard_cnt;
        hold_cnt_nxt   = hold_cnt;
        start          = 1'b0;
        tgt            = sel_q;
        leave          = 1'b0;
        preempt        = 1'b0;

        // Single request wins outright; a tie goes to the one that did not own last.
        unique case (bus.req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_owner;
            default: win = 1'b0;
        endcase

        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    start = 1'b1;
                    tgt   = win;
                end
            end

            GUARD: begin
                if (!bus.req[sel_q]) begin
                    // Pending winner gave up: hand over to the other side or go idle.
                    if (bus.req[~sel_q]) begin
                        start = 1'b1;
                        tgt   = ~sel_q;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (guard_cnt >= GUARD_C) begin
                    state_nxt      = OWN;
                    hold_cnt_nxt   = CNT_ONE;
                    last_owner_nxt = sel_q;
                end else begin
                    guard_cnt_nxt = guard_cnt + CNT_ONE;
                end
            end

            OWN: begin
                if (hold_cnt != CNT_MAX) begin
                    hold_cnt_nxt = hold_cnt + CNT_ONE;
                end
                preempt = (MAX_HOLD != 0) && bus.req[~sel_q] && (hold_cnt >= HOLD_LIM_C);
                leave   = !bus.req[sel_q] || preempt;
                if (leave) begin
                    if (bus.req[~sel_q]) begin
                        start = 1'b1;
                        tgt   = ~sel_q;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Common routing entry: straight to OWN when sel already matches (or no
        // guard is configured), otherwise toggle sel and (re)start the guard.
        if (start) begin
            sel_nxt = tgt;
            if ((tgt == sel_q) || (GUARD_CYCLES == 0)) begin
                state_nxt      = OWN;
                hold_cnt_nxt   = CNT_ONE;
                last_owner_nxt = tgt;
            end else begin
                state_nxt     = GUARD;
                guard_cnt_nxt = CNT_ONE;
            end
        end
    end

    // Output logic: decode the next state into the values registered next edge.
    always_comb begin
        gnt_nxt      = 2'b00;
        route_en_nxt = 1'b0;
        busy_nxt     = (state_nxt != IDLE);
        if (state_nxt == OWN) begin
            gnt_nxt      = sel_nxt ? 2'b10 : 2'b01;
            route_en_nxt = 1'b1;
        end
    end

`ifdef DEMUX_ROUTE_SCHED_STATS_EN
    // Switch statistics: count every sel toggle, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            switch_cnt <= 16'h0000;
        end else if ((sel_nxt != sel_q) && (switch_cnt != 16'hFFFF)) begin
            switch_cnt <= switch_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_demux_route_sched.sv
// tb_demux_route_sched: directed bench for demux_route_sched.
// dut_a uses default parameters, dut_b has MIN_HOLD=16/MAX_HOLD=8,
// dut_c has GUARD_CYCLES=0. All three share clk, rst and the req stimulus.
module tb_demux_route_sched;

    logic clk;
    logic rst;

    demux_route_sched_if bus_a ();
    demux_route_sched_if bus_b ();
    demux_route_sched_if bus_c ();

`ifdef DEMUX_ROUTE_SCHED_STATS_EN
    logic [15:0] sc_a;
    logic [15:0] sc_b;
    logic [15:0] sc_c;
`endif

    demux_route_sched #(.GUARD_CYCLES(4), .MIN_HOLD(16), .MAX_HOLD(256), .CNT_W(9)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
`ifdef DEMUX_ROUTE_SCHED_STATS_EN
        ,
        .switch_cnt(sc_a)
`endif
    );

    demux_route_sched #(.GUARD_CYCLES(4), .MIN_HOLD(16), .MAX_HOLD(8), .CNT_W(9)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
`ifdef DEMUX_ROUTE_SCHED_STATS_EN
        ,
        .switch_cnt(sc_b)
`endif
    );

    demux_route_sched #(.GUARD_CYCLES(0), .MIN_HOLD(16), .MAX_HOLD(0), .CNT_W(9)) dut_c (
        .clk(clk),
        .rst(rst),
        .bus(bus_c)
`ifdef DEMUX_ROUTE_SCHED_STATS_EN
        ,
        .switch_cnt(sc_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errs;

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic       sel;
        logic       re;
        logic       busy;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive req away from the edge, then sample 1 time unit after the edge.
    task automatic step(input logic [1:0] r);
        @(negedge clk);
        bus_a.req = r;
        bus_b.req = r;
        bus_c.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_a.req = 2'b00;
        bus_b.req = 2'b00;
        bus_c.req = 2'b00;
        @(posedge clk);
        #1;
        check("rst_gnt",  bus_a.gnt, 2'b00);
        check("rst_sel",  bus_a.sel, 1'b0);
        check("rst_re",   bus_a.route_en, 1'b0);
        check("rst_busy", bus_a.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        n_checks  = 0;
        n_errs    = 0;
        rst       = 1'b0;
        bus_a.req = 2'b00;
        bus_b.req = 2'b00;
        bus_c.req = 2'b00;

        //            req    gnt    sel   re    busy
        vecs[0]  = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b1};  // grant with 1-cycle latency, no guard
        vecs[1]  = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1};  // release + other: sel flips, guard 1
        vecs[3]  = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1};  // guard 4
        vecs[6]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0};  // release to IDLE, sel held
        vecs[8]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b1};  // same path: no guard
        vecs[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b1};  // tie, last owner 1 -> path 0
        vecs[12] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1};  // release before MIN_HOLD
        vecs[17] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0};  // winner drops in guard, none other
        vecs[18] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1};  // guard restart toward 1
        vecs[20] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1};  // guard restart toward 0
        vecs[21] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[22] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[24] = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b1};
        vecs[25] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        // Table-driven sequence on dut_a.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            step(vecs[i].req);
            check($sformatf("v%0d_gnt", i),  bus_a.gnt,      vecs[i].gnt);
            check($sformatf("v%0d_sel", i),  bus_a.sel,      vecs[i].sel);
            check($sformatf("v%0d_re", i),   bus_a.route_en, vecs[i].re);
            check($sformatf("v%0d_busy", i), bus_a.busy,     vecs[i].busy);
        end

        // MAX_HOLD preemption (dut_a) and MIN_HOLD floor (dut_b), both reqs held.
        do_reset();
        step(2'b11);
        check("pre_first_gnt", bus_a.gnt, 2'b01);
        cnt = 0;
        while (bus_a.gnt == 2'b01 && cnt < 600) begin
            if (cnt == 16) check("minhold_b_gnt", bus_b.gnt, 2'b00);
            cnt++;
            step(2'b11);
        end
        check("maxhold_own_cycles", cnt, 256);
        check("maxhold_sel", bus_a.sel, 1'b1);
        cnt = 0;
        while (bus_a.gnt == 2'b00 && cnt < 20) begin
            if (bus_a.route_en !== 1'b0) check("maxhold_guard_re", bus_a.route_en, 1'b0);
            cnt++;
            step(2'b11);
        end
        check("maxhold_guard_cycles", cnt, 4);
        check("maxhold_new_gnt", bus_a.gnt, 2'b10);
        check("maxhold_new_re", bus_a.route_en, 1'b1);

        do_reset();
        step(2'b11);
        cnt = 0;
        while (bus_b.gnt == 2'b01 && cnt < 100) begin
            cnt++;
            step(2'b11);
        end
        check("minhold_own_cycles", cnt, 16);
        check("minhold_sel", bus_b.sel, 1'b1);

        // GUARD_CYCLES=0: sel change and grant on the same edge (dut_c).
        do_reset();
        step(2'b10);
        check("g0_gnt_1", bus_c.gnt, 2'b10);
        check("g0_sel_1", bus_c.sel, 1'b1);
        step(2'b01);
        check("g0_gnt_0", bus_c.gnt, 2'b01);
        check("g0_re_0",  bus_c.route_en, 1'b1);

`ifdef DEMUX_ROUTE_SCHED_STATS_EN
        // Guard restart counts both toggles.
        do_reset();
        check("sc_reset", sc_a, 16'd0);
        step(2'b10);
        check("sc_first", sc_a, 16'd1);
        step(2'b01);
        check("sc_restart", sc_a, 16'd2);
`endif

        // Asynchronous reset mid-OWN on path 1, then a full guard afterwards.
        do_reset();
        for (int i = 0; i < 5; i++) step(2'b10);
        check("arst_pre_gnt", bus_a.gnt, 2'b10);
        #2;
        rst = 1'b1;
        bus_a.req = 2'b00;
        bus_b.req = 2'b00;
        bus_c.req = 2'b00;
        #1;
        check("arst_gnt",  bus_a.gnt, 2'b00);
        check("arst_sel",  bus_a.sel, 1'b0);
        check("arst_re",   bus_a.route_en, 1'b0);
        check("arst_busy", bus_a.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(2'b10);
        check("arst_guard_sel", bus_a.sel, 1'b1);
        cnt = 0;
        while (bus_a.gnt == 2'b00 && cnt < 20) begin
            cnt++;
            step(2'b10);
        end
        check("arst_guard_cycles", cnt, 4);
        check("arst_final_gnt", bus_a.gnt, 2'b10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
